// File: rtl/acortex_st_upsizer_16to32.sv
// acortex_st_upsizer_16to32
//   Avalon-ST adapter that packs a 16-bit audio sample stream into 32-bit
//   words for the limbus_sys fabric. The first beat of each pair lands in the
//   upper half of the output word. Packet framing (sop/eop/empty) is kept.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_ready                sink ready (depends only on output register state)
//   in_valid                sink beat valid
//   in_data[15:0]           sink data, [15:8] is the first symbol
//   in_startofpacket        first beat of a packet
//   in_endofpacket          last beat of a packet
//   in_empty                empty symbols in the last beat (used only with eop)
//   out_ready               source backpressure
//   out_valid               source word valid
//   out_data[31:0]          packed word, [31:16] first beat, [15:0] second beat
//   out_startofpacket       word holds the packet's first beat
//   out_endofpacket         word holds the packet's last beat
//   out_empty[1:0]          empty symbols in the last word
//   err_orphan              one-cycle pulse: held half-word dropped because a
//                           new sop arrived before the previous packet's eop
module acortex_st_upsizer_16to32 (
  input  logic        clk,
  input  logic        reset_n,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic        in_empty,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic        err_orphan
);

  typedef enum logic {
    PH_HI = 1'b0,  // waiting for the upper half of a word
    PH_LO = 1'b1   // upper half held, waiting for the lower half
  } phase_t;

  phase_t      phase;
  phase_t      phase_nxt;
  logic [15:0] hold_data;
  logic        hold_sop;

  logic        accept;
  logic        produce;
  logic        store;
  logic        orphan;
  logic [31:0] word_data;
  logic        word_sop;
  logic        word_eop;
  logic [1:0]  word_empty;

  // The output register can take a new word whenever it is empty or being
  // drained; every accepted beat therefore has a free output slot.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    phase_nxt  = phase;
    produce    = 1'b0;
    store      = 1'b0;
    orphan     = 1'b0;
    word_data  = 32'h0000_0000;
    word_sop   = 1'b0;
    word_eop   = 1'b0;
    word_empty = 2'd0;
    if (accept) begin
      // A sop while a half is held restarts packing: the held half is dropped.
      if ((phase == PH_HI) || in_startofpacket) begin
        orphan = (phase == PH_LO);
        if (in_endofpacket) begin
          // Lone last beat: pad the lower half and count it as empty.
          produce    = 1'b1;
          word_data  = {in_data, 16'h0000};
          word_sop   = in_startofpacket;
          word_eop   = 1'b1;
          word_empty = 2'd2 + {1'b0, in_empty};
          phase_nxt  = PH_HI;
        end else begin
          store     = 1'b1;
          phase_nxt = PH_LO;
        end
      end else begin
        produce    = 1'b1;
        word_data  = {hold_data, in_data};
        word_sop   = hold_sop;
        word_eop   = in_endofpacket;
        word_empty = in_endofpacket ? {1'b0, in_empty} : 2'd0;
        phase_nxt  = PH_HI;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase             <= PH_HI;
      hold_data         <= 16'h0000;
      hold_sop          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= 32'h0000_0000;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 2'd0;
      err_orphan        <= 1'b0;
    end else begin
      err_orphan <= orphan;
      if (accept) begin
        phase <= phase_nxt;
      end
      if (store) begin
        hold_data <= in_data;
        hold_sop  <= in_startofpacket;
      end
      // Output stage: reload when free; valid drops if nothing was produced.
      if (in_ready) begin
        out_valid <= produce;
        if (produce) begin
          out_data          <= word_data;
          out_startofpacket <= word_sop;
          out_endofpacket   <= word_eop;
          out_empty         <= word_empty;
        end
      end
    end
  end

endmodule

// File: tb/tb_acortex_st_upsizer_16to32.sv
module tb_acortex_st_upsizer_16to32;

  logic        clk;
  logic        reset_n;
  logic        in_ready;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        in_empty;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic        err_orphan;

  acortex_st_upsizer_16to32 dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .err_orphan        (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    orphan_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    word_t w;
    w.data = d; w.sop = s; w.eop = e; w.empty = em;
    exp_q.push_back(w);
  endtask

  // Monitor: every word transferred on the source side is compared against
  // the head of the expectation queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      word_t got;
      word_t req;
      got.data = out_data; got.sop = out_startofpacket;
      got.eop = out_endofpacket; got.empty = out_empty;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=0x%08h sop=%0b eop=%0b empty=%0d, expected none",
                 got.data, got.sop, got.eop, got.empty);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_fail++;
          $display("FAIL word: got data=0x%08h sop=%0b eop=%0b empty=%0d, expected data=0x%08h sop=%0b eop=%0b empty=%0d",
                   got.data, got.sop, got.eop, got.empty, req.data, req.sop, req.eop, req.empty);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && err_orphan) orphan_pulses++;
  end

  // Present one beat and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [15:0] d, input logic s, input logic e, input logic em);
    bit ok;
    int cyc;
    in_valid = 1'b1; in_data = d;
    in_startofpacket = s; in_endofpacket = e; in_empty = em;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat 0x%04h not accepted after %0d cycles, expected acceptance", d, cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_sop_eop_empty"},
          64'({out_startofpacket, out_endofpacket, out_empty}), 64'd0);
    check({tag, "_err_orphan"}, 64'(err_orphan), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] held;
    int waited;

    reset_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = 16'h0;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Even packet, with latency checks on each completing beat.
    expect_word(32'h1122_3344, 1'b1, 1'b0, 2'd0);
    expect_word(32'h5566_7788, 1'b0, 1'b1, 2'd0);
    send(16'h1122, 1'b1, 1'b0, 1'b0);
    check("even_no_word_after_first_half", 64'(out_valid), 64'd0);
    send(16'h3344, 1'b0, 1'b0, 1'b0);
    check("even_word0_latency", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'h1122_3344});
    send(16'h5566, 1'b0, 1'b0, 1'b0);
    send(16'h7788, 1'b0, 1'b1, 1'b0);
    check("even_word1_latency", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'h5566_7788});

    // Odd packet, then a single-beat packet to confirm phase is back to HI.
    expect_word(32'hAAAA_BBBB, 1'b1, 1'b0, 2'd0);
    expect_word(32'hCC00_0000, 1'b0, 1'b1, 2'd3);
    expect_word(32'hDEAD_0000, 1'b1, 1'b1, 2'd2);
    send(16'hAAAA, 1'b1, 1'b0, 1'b0);
    send(16'hBBBB, 1'b0, 1'b0, 1'b0);
    send(16'hCC00, 1'b0, 1'b1, 1'b1);
    send(16'hDEAD, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Backpressure: stall the output for 5 cycles while beats keep coming.
    expect_word(32'h0101_0202, 1'b1, 1'b0, 2'd0);
    expect_word(32'h0303_0404, 1'b0, 1'b0, 2'd0);
    expect_word(32'h0505_0606, 1'b0, 1'b0, 2'd0);
    expect_word(32'h0707_0808, 1'b0, 1'b1, 2'd0);
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send({i[7:0], i[7:0]}, i == 1, i == 8, 1'b0);
      end
      begin
        waited = 0;
        while (!out_valid && waited < 50) begin
          @(posedge clk); #1;
          waited++;
        end
        check("bp_word_appeared", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = out_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_out_data_stable", 64'(out_data), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    check("bp_all_words_delivered", 64'(exp_q.size()), 64'd0);

    // Orphan: a second sop while a half is held drops the held half.
    expect_word(32'h5678_9ABC, 1'b1, 1'b1, 2'd0);
    send(16'h1234, 1'b1, 1'b0, 1'b0);
    check("orphan_no_pulse_yet", 64'(err_orphan), 64'd0);
    send(16'h5678, 1'b1, 1'b0, 1'b0);
    check("orphan_pulse", 64'(err_orphan), 64'd1);
    @(posedge clk); #1;
    check("orphan_pulse_one_cycle", 64'(err_orphan), 64'd0);
    send(16'h9ABC, 1'b0, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("orphan_pulse_count", 64'(orphan_pulses), 64'd1);

    // Reset mid-word: held half is lost, no orphan pulse.
    send(16'h1111, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_word(32'h2222_3333, 1'b1, 1'b1, 2'd0);
    send(16'h2222, 1'b1, 1'b0, 1'b0);
    send(16'h3333, 1'b0, 1'b1, 1'b0);
    check("midreset_word", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'h2222_3333});
    repeat (4) begin @(posedge clk); #1; end
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_orphan_count", 64'(orphan_pulses), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acortex_st_upsizer_16to32.md
# acortex_st_upsizer_16to32

Avalon-ST data-format adapter that packs a 16-bit audio sample stream into 32-bit words. It is the return-path counterpart of the acortex 32→16 downsizer and sits between the 16-bit acortex codec sink and the 32-bit limbus_sys streaming fabric. It preserves packet framing: start/end-of-packet and empty-byte count. The first 16-bit beat of each pair occupies the upper half of the output word.

## Interface
- No parameters; widths fixed (in 16 bits / 2 symbols, out 32 bits / 4 symbols, 8-bit symbols).
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_ready  out  1  sink ready
- in_valid  in  1  sink beat valid
- in_data  in  16  sink data; [15:8] is first symbol
- in_startofpacket  in  1  first beat of packet
- in_endofpacket  in  1  last beat of packet
- in_empty  in  1  empty symbols in last beat; ignored unless in_endofpacket
- out_ready  in  1  source backpressure
- out_valid  out  1  source word valid
- out_data  out  32  packed word; [31:16] is first beat, [15:0] is second beat
- out_startofpacket  out  1  word holds packet's first beat
- out_endofpacket  out  1  word holds packet's last beat
- out_empty  out  2  empty symbols in last word
- err_orphan  out  1  one-cycle pulse: half-word discarded by protocol violation

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = ~out_valid || out_ready. Purely combinational from the output register. No dependency on in_valid or in_data.
- Phase state machine, 1 bit:
  - HI (reset): waiting for the upper half.
  - LO: upper half held in hold_data[15:0], hold_sop.
- HI, accepted beat, no eop: hold_data ← in_data; hold_sop ← in_startofpacket; go to LO. No output is loaded.
- HI, accepted beat with eop (flush): load the output with
  - data = {in_data, 16'h0000}
  - sop = in_startofpacket, eop = 1
  - empty = 2 + in_empty
  - Stay in HI.
- LO, accepted beat, no sop: load the output with
  - data = {hold_data, in_data}
  - sop = hold_sop
  - eop = in_endofpacket
  - empty = in_endofpacket ? in_empty : 0
  - Go to HI.
- LO, accepted beat with in_startofpacket (previous packet lacked eop):
  - Discard hold_data and pulse err_orphan the next cycle.
  - Treat the beat as a HI beat: store it and go to LO, or flush it if it also has eop.
- Sop in HI is normal. A missing sop is not checked. Beats between packets are passed through as data.
- Output register loads only when out_ready || ~out_valid. On a load, out_valid ← (a word is produced this cycle), so it clears when nothing is produced.
- Arithmetic: out_empty is 2 bits. 2 + in_empty ≤ 3, so there is no overflow.

## Timing
- Reset values: out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, err_orphan all 0. Phase = HI, hold registers 0.
- in_ready = 1 during and immediately after reset, because out_valid = 0.
- Latency: the word is visible on the output one cycle after the clock edge that accepts its completing beat (the second beat, or the flush beat).
- Throughput: one input beat per cycle sustained with out_ready = 1. One output word per two input beats.
- Backpressure: with out_valid = 1 and out_ready = 0:
  - in_ready = 0.
  - All out_* signals are held stable.
  - Phase and hold registers are frozen.
- Reset mid-word: the held half is lost with no err_orphan. The next accepted beat is treated as HI.
- in_data and in_startofpacket/in_endofpacket are sampled only on accept. Values while in_valid = 0 are ignored.
- err_orphan is registered and asserts the cycle after the violating accept, for exactly 1 cycle.

## Test plan
- Even packet: beats 0x1122 (sop), 0x3344, 0x5566, 0x7788 (eop, empty 0), out_ready = 1 → 0x11223344 with sop=1 eop=0, then 0x55667788 with sop=0 eop=1 empty=0. Each word appears 1 cycle after its 2nd beat.
- Odd packet: 0xAAAA (sop), 0xBBBB, 0xCC00 (eop, empty 1) → 0xAAAABBBB (sop), then 0xCC000000 with eop=1 and empty=3. Phase returns to HI.
- Single-beat packet: 0xDEAD with sop+eop, empty 0 → 0xDEAD0000 with sop=1 eop=1 empty=2.
- Backpressure: drive continuous beats, and hold out_ready = 0 for 5 cycles while out_valid = 1 → in_ready = 0, out_data unchanged throughout. After release, the word sequence is complete with no duplicates or loss.
- Orphan: 0x1234 (sop, no eop), then 0x5678 (sop), 0x9ABC (eop) → err_orphan pulses once; only 0x56789ABC is output, with sop=1 eop=1 empty=0. 0x1234 never appears.
- Reset mid-word: accept 0x1111 (sop), then pulse reset_n low → all outputs 0 and in_ready = 1. Next packet 0x2222 (sop), 0x3333 (eop) → 0x22223333.
